// File: rtl/msx_io_pkg.sv
// Shared definitions for the MSX I/O capture front end:
// port codes, capture FSM states and the sound-chip port decoder.
package msx_io_pkg;

    localparam logic [2:0] PORT_TEST0   = 3'd0;
    localparam logic [2:0] PORT_TEST1   = 3'd1;
    localparam logic [2:0] PORT_OPLL_A  = 3'd2;
    localparam logic [2:0] PORT_OPLL_D  = 3'd3;
    localparam logic [2:0] PORT_PSG_A   = 3'd4;
    localparam logic [2:0] PORT_PSG_D   = 3'd5;
    localparam logic [2:0] PORT_AUDIO_A = 3'd6;
    localparam logic [2:0] PORT_AUDIO_D = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        WAIT_HI,
        HOLD
    } state_t;

    // Returns {hit, code}. Test ports only hit when enabled.
    function automatic logic [3:0] decode(
        input logic [7:0] addr,
        input logic       test_ports
    );
        logic [3:0] r;
        case (addr)
            8'h00:   r = {test_ports, PORT_TEST0};
            8'h01:   r = {test_ports, PORT_TEST1};
            8'h7C:   r = {1'b1, PORT_OPLL_A};
            8'h7D:   r = {1'b1, PORT_OPLL_D};
            8'hA0:   r = {1'b1, PORT_PSG_A};
            8'hA1:   r = {1'b1, PORT_PSG_D};
            8'hC0:   r = {1'b1, PORT_AUDIO_A};
            8'hC1:   r = {1'b1, PORT_AUDIO_D};
            default: r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/msx_io_capture_sync2.sv
// Two-flop synchronizer, parameter width and reset value.
// Ports: clk, rst (sync, active high), d (async in), q (synchronized out).
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/msx_io_capture.sv
// MSX I/O write capture: synchronizes the bus, filters short strobes,
// decodes sound-chip ports and emits one valid/ready beat per OUT cycle.
// Ports: clk, rst (sync, active high); msx_iorq_n, msx_wr_n, msx_ad,
// msx_dt (async bus); out_valid/out_ready/out_ad/out_dt (beat);
// glitch_cnt, overrun_cnt (saturating error counters).
module msx_io_capture
    import msx_io_pkg::*;
#(
    parameter int MIN_LOW    = 4,
    parameter int HOLDOFF    = 2,
    parameter int TEST_PORTS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msx_iorq_n,
    input  logic       msx_wr_n,
    input  logic [7:0] msx_ad,
    input  logic [7:0] msx_dt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_ad,
    output logic [7:0] out_dt,
    output logic [7:0] glitch_cnt,
    output logic [7:0] overrun_cnt
);

    localparam logic [3:0] MIN_LOW_C = 4'(MIN_LOW);
    localparam logic [3:0] HOLD_C    = 4'(HOLDOFF);

    logic [1:0]  strobe_s;
    logic [15:0] bus_s;
    logic        act;
    logic [3:0]  dec;

    sync2 #(.WIDTH(2), .RST_VAL(2'b11)) u_strobe (
        .clk (clk),
        .rst (rst),
        .d   ({msx_iorq_n, msx_wr_n}),
        .q   (strobe_s)
    );

    sync2 #(.WIDTH(16), .RST_VAL(16'h0000)) u_bus (
        .clk (clk),
        .rst (rst),
        .d   ({msx_ad, msx_dt}),
        .q   (bus_s)
    );

    assign act = ~strobe_s[1] & ~strobe_s[0];
    assign dec = decode(bus_s[15:8], TEST_PORTS != 0);

    state_t     state, state_nx;
    logic [3:0] lowcnt, lowcnt_nx;
    logic [3:0] holdcnt, holdcnt_nx;
    logic       sh_hit;
    logic [2:0] sh_ad;
    logic [7:0] sh_dt;
    logic       latch, commit, glitch;

    // The LOW check on lowcnt comes first: once MIN_LOW active cycles
    // have been counted the write is taken even if act just dropped.
    always_comb begin
        state_nx   = state;
        lowcnt_nx  = lowcnt;
        holdcnt_nx = holdcnt;
        latch      = 1'b0;
        commit     = 1'b0;
        glitch     = 1'b0;
        unique case (state)
            IDLE: begin
                if (act) begin
                    lowcnt_nx = 4'd1;
                    state_nx  = LOW;
                end
            end
            LOW: begin
                if (lowcnt == MIN_LOW_C) begin
                    latch    = 1'b1;
                    state_nx = WAIT_HI;
                end else if (!act) begin
                    glitch   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    lowcnt_nx = lowcnt + 4'd1;
                end
            end
            WAIT_HI: begin
                if (!act) begin
                    commit     = sh_hit;
                    holdcnt_nx = HOLD_C;
                    state_nx   = (HOLD_C == 4'd0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                holdcnt_nx = holdcnt - 4'd1;
                if (holdcnt <= 4'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lowcnt  <= 4'd0;
            holdcnt <= 4'd0;
            sh_hit  <= 1'b0;
            sh_ad   <= 3'd0;
            sh_dt   <= 8'd0;
        end else begin
            state   <= state_nx;
            lowcnt  <= lowcnt_nx;
            holdcnt <= holdcnt_nx;
            if (latch) begin
                sh_hit <= dec[3];
                sh_ad  <= dec[2:0];
                sh_dt  <= bus_s[7:0];
            end
        end
    end

    // Single-entry output register; a commit that finds it full and
    // not draining is dropped and counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_ad      <= 3'd0;
            out_dt      <= 8'd0;
            glitch_cnt  <= 8'd0;
            overrun_cnt <= 8'd0;
        end else begin
            if (commit) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_ad    <= sh_ad;
                    out_dt    <= sh_dt;
                end else if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (glitch && glitch_cnt != 8'hFF) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_msx_io_capture.sv
// Bench for msx_io_capture: transaction-level model of strobes predicts
// beats and counters for two instances (test ports on / off).
module tb_msx_io_capture;

    localparam int ML = 4;
    localparam int HO = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iorq_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] ad = 8'h00;
    logic [7:0] dt = 8'h00;
    logic       ready = 1'b0;

    logic       v0, v1;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1, g0, g1, o0, o1;

    always #5 clk = ~clk;

    msx_io_capture #(.MIN_LOW(ML), .HOLDOFF(HO), .TEST_PORTS(1)) dut0 (
        .clk(clk), .rst(rst), .msx_iorq_n(iorq_n), .msx_wr_n(wr_n),
        .msx_ad(ad), .msx_dt(dt), .out_valid(v0), .out_ready(ready),
        .out_ad(a0), .out_dt(d0), .glitch_cnt(g0), .overrun_cnt(o0)
    );

    msx_io_capture #(.MIN_LOW(ML), .HOLDOFF(HO), .TEST_PORTS(0)) dut1 (
        .clk(clk), .rst(rst), .msx_iorq_n(iorq_n), .msx_wr_n(wr_n),
        .msx_ad(ad), .msx_dt(dt), .out_valid(v1), .out_ready(ready),
        .out_ad(a1), .out_dt(d1), .glitch_cnt(g1), .overrun_cnt(o1)
    );

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] dt;
        logic       hit0;
        logic       hit1;
    } ev_t;

    ev_t  ev_commit[int];
    bit   ev_glitch[int];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    bit   rand_ready = 1'b0;

    logic       mv[2];
    logic [2:0] mad[2];
    logic [7:0] mdt[2];
    int         mg[2];
    int         mo[2];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                     name, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [7:0] a,
                                              input bit tp);
        case (a)
            8'h00:   return tp ? 4'h8 : 4'h0;
            8'h01:   return tp ? 4'h9 : 4'h0;
            8'h7C:   return 4'hA;
            8'h7D:   return 4'hB;
            8'hA0:   return 4'hC;
            8'hA1:   return 4'hD;
            8'hC0:   return 4'hE;
            8'hC1:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // Model: applies the predicted per-edge events to the output register.
    initial begin
        ev_t e;
        bit  cm;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 0; mad[d] = 0; mdt[d] = 0; mg[d] = 0; mo[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    mv[d] = 0; mad[d] = 0; mdt[d] = 0; mg[d] = 0; mo[d] = 0;
                end else begin
                    cm = 0;
                    if (ev_commit.exists(cyc)) begin
                        e  = ev_commit[cyc];
                        cm = (d == 0) ? e.hit0 : e.hit1;
                    end
                    if (cm) begin
                        if (!mv[d] || ready) begin
                            mv[d] = 1; mad[d] = e.code; mdt[d] = e.dt;
                        end else if (mo[d] < 255) begin
                            mo[d]++;
                        end
                    end else if (ready) begin
                        mv[d] = 0;
                    end
                    if (ev_glitch.exists(cyc) && mg[d] < 255) mg[d]++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid0", 32'(v0), 32'(mv[0]));
                if (mv[0]) begin
                    check("ad0", 32'(a0), 32'(mad[0]));
                    check("dt0", 32'(d0), 32'(mdt[0]));
                end
                check("glitch0", 32'(g0), 32'(mg[0]));
                check("overrun0", 32'(o0), 32'(mo[0]));
                check("valid1", 32'(v1), 32'(mv[1]));
                if (mv[1]) begin
                    check("ad1", 32'(a1), 32'(mad[1]));
                    check("dt1", 32'(d1), 32'(mdt[1]));
                end
                check("glitch1", 32'(g1), 32'(mg[1]));
                check("overrun1", 32'(o1), 32'(mo[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Pins low for len cycles. Accepted commit lands 3 edges after release;
    // a glitch is counted 3 edges after release as well.
    task automatic strobe(input logic [7:0] a, input logic [7:0] d,
                          input int len, input int gap);
        int         e;
        logic [3:0] r0, r1;
        e      = cyc;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        ad     = a;
        dt     = d;
        r0     = ref_decode(a, 1'b1);
        r1     = ref_decode(a, 1'b0);
        if (len > ML)
            ev_commit[e + len + 3] = '{r0[2:0], d, r0[3], r1[3]};
        else if (len < ML)
            ev_glitch[e + len + 3] = 1'b1;
        idle(len);
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        ad     = 8'($urandom);
        dt     = 8'($urandom);
        idle(gap);
    endtask

    task automatic wait_commit();
        idle(3);
        @(negedge clk);
    endtask

    logic [7:0] addrs[10];
    int         len;

    initial begin
        addrs = '{8'h00, 8'h01, 8'h7C, 8'h7D, 8'hA0,
                  8'hA1, 8'hC0, 8'hC1, 8'h98, 8'hFF};

        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(v0), 0);
        check("rst_ad", 32'(a0), 0);
        check("rst_dt", 32'(d0), 0);
        check("rst_glitch", 32'(g0), 0);
        check("rst_overrun", 32'(o0), 0);

        ready = 1'b1;
        strobe(8'h7C, 8'h5A, 10, 0);
        wait_commit();
        check("acc_valid", 32'(v0), 1);
        check("acc_ad", 32'(a0), 2);
        check("acc_dt", 32'(d0), 32'h5A);
        idle(1);
        @(negedge clk);
        check("acc_drop", 32'(v0), 0);
        check("acc_glitch", 32'(g0), 0);
        check("acc_overrun", 32'(o0), 0);
        idle(8);

        strobe(8'h7C, 8'h33, 2, 6);
        @(negedge clk);
        check("glitch_one", 32'(g0), 1);
        check("glitch_noval", 32'(v0), 0);
        repeat (299) strobe(8'h7C, 8'h33, 2, 4);
        @(negedge clk);
        check("glitch_sat", 32'(g0), 255);

        strobe(8'h98, 8'h11, 10, 0);
        wait_commit();
        check("nohit_valid", 32'(v0), 0);
        check("nohit_overrun", 32'(o0), 0);
        idle(8);
        strobe(8'h01, 8'h22, 10, 0);
        wait_commit();
        check("tp1_valid", 32'(v0), 1);
        check("tp1_ad", 32'(a0), 1);
        check("tp0_valid", 32'(v1), 0);
        idle(8);

        ready = 1'b0;
        strobe(8'hA0, 8'h07, 6, 8);
        strobe(8'hA1, 8'h3F, 6, 0);
        wait_commit();
        check("bp_valid", 32'(v0), 1);
        check("bp_ad", 32'(a0), 4);
        check("bp_dt", 32'(d0), 32'h07);
        check("bp_overrun", 32'(o0), 1);
        idle(1);
        ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("bp_drain", 32'(v0), 0);
        idle(6);

        ready = 1'b0;
        strobe(8'hC0, 8'h44, 6, 8);
        strobe(8'hC1, 8'h55, 6, 0);
        idle(2);
        ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("sim_valid", 32'(v0), 1);
        check("sim_ad", 32'(a0), 7);
        check("sim_dt", 32'(d0), 32'h55);
        check("sim_overrun", 32'(o0), 1);
        idle(8);

        iorq_n = 1'b0;
        wr_n   = 1'b0;
        ad     = 8'hC1;
        dt     = 8'h77;
        idle(8);
        rst = 1'b1;
        idle(1);
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(6);
        @(negedge clk);
        check("rmid_valid", 32'(v0), 0);
        check("rmid_ad", 32'(a0), 0);
        check("rmid_dt", 32'(d0), 0);
        check("rmid_glitch", 32'(g0), 0);
        check("rmid_overrun", 32'(o0), 0);
        strobe(8'h7D, 8'h66, 8, 0);
        wait_commit();
        check("post_valid", 32'(v0), 1);
        check("post_ad", 32'(a0), 3);
        check("post_dt", 32'(d0), 32'h66);
        idle(8);

        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, ML - 1);
            else len = $urandom_range(ML + 1, 12);
            strobe(addrs[$urandom_range(0, 9)], 8'($urandom), len,
                   $urandom_range(HO + 4, HO + 10));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
